perceptron_train: RTL and testbench
===================================

PERCEPTRON_TRAIN -- requirements
Module: perceptron_train

Interface
REQ-001 The block SHALL have parameter NIN, default 2, the number of binary inputs per sample (1..8).
REQ-002 The block SHALL have parameter WW, default 8, the signed weight and bias width.
REQ-003 The block SHALL have parameter NSAMP, default 4, the sample-memory depth (2..16); AW = clog2(NSAMP).
REQ-004 The block SHALL have parameter EPW, default 4, the epoch-counter width.
REQ-005 The block SHALL have one clock and an asynchronous, active-high reset; both are listed below.
REQ-006 The block SHALL have port clk, input, width 1: the single clock; all state updates on its rising edge.
REQ-007 The block SHALL have port rst, input, width 1: asynchronous, active-high reset.
REQ-008 The block SHALL have port start, input, width 1: one-cycle training request.
REQ-009 The block SHALL have port max_ep, input, width EPW: epoch limit, sampled at start.
REQ-010 The block SHALL have port thr, input, width WW (signed): activation threshold, sampled at start.
REQ-011 The block SHALL have ports wr_en, wr_addr[AW], wr_x[NIN] and wr_y[1] as inputs: the sample-memory write port.
REQ-012 The block SHALL have port busy, output, width 1: training in progress.
REQ-013 The block SHALL have port done, output, width 1: one-cycle pulse at training end.
REQ-014 The block SHALL have port converged, output, width 1: the last run ended with an error-free epoch.
REQ-015 The block SHALL have port epochs_used, output, width EPW: epochs completed in the last or current run.
REQ-016 The block SHALL have port w_flat, output, width NIN*WW (signed fields): w[i] occupies bits [i*WW +: WW].
REQ-017 The block SHALL have port bias, output, width WW (signed): the learned bias weight.

Function
REQ-018 The sample memory SHALL hold NSAMP entries of {x, y}; a write with wr_en=1 while busy=0 SHALL store {wr_x, wr_y} at wr_addr on the next edge.
REQ-019 Writes with wr_en=1 while busy=1, and writes with wr_addr>=NSAMP, SHALL be ignored.
REQ-020 The FSM SHALL have exactly the states IDLE, EVAL, UPDATE, EPEND and FIN.
REQ-021 In IDLE, start=1 SHALL clear all weights, bias, the sample index, epochs_used and converged; it SHALL latch max_ep and thr, and enter EVAL, or FIN if the latched max_ep=0.
REQ-022 start SHALL be ignored in every state other than IDLE.
REQ-023 In EVAL the block SHALL compute sum = bias + sum of w[i] over all i with x[i]=1, signed, in WW+clog2(NIN+1) bits, with no overflow.
REQ-024 In EVAL the block SHALL compute y_pred = (sum >= thr) and register err = y - y_pred, where err is one of {-1, 0, +1}.
REQ-025 In EVAL the block SHALL set the epoch error flag when err != 0, then enter UPDATE.
REQ-026 In UPDATE the block SHALL apply w[i] <= sat(w[i] + err*x[i]) and bias <= sat(bias + err).
REQ-027 sat() SHALL clamp to the range [-2^(WW-1), 2^(WW-1)-1].
REQ-028 Processing one sample SHALL take exactly 2 cycles (EVAL then UPDATE), taken in address order 0..NSAMP-1.
REQ-029 From UPDATE, the block SHALL go to EVAL with index+1 if index < NSAMP-1; otherwise it SHALL go to EPEND.
REQ-030 On entering EPEND, epochs_used SHALL be incremented by 1.
REQ-031 In EPEND, if the error flag is 0 the block SHALL set converged=1 and enter FIN.
REQ-032 In EPEND, otherwise, if epochs_used = latched max_ep the block SHALL enter FIN with converged=0.
REQ-033 In EPEND, otherwise the block SHALL clear the error flag and the index and enter EVAL.
REQ-034 In FIN the block SHALL assert done for exactly one cycle, then return to IDLE.
REQ-035 busy SHALL be 1 in EVAL, UPDATE and EPEND, and 0 in IDLE and FIN.
REQ-036 After FIN, weights, bias, converged and epochs_used SHALL hold their values until the next accepted start.
REQ-037 Changes to max_ep and thr during busy SHALL have no effect on the current run.

Reset
REQ-038 rst=1 SHALL immediately force IDLE with busy=0, done=0, converged=0, epochs_used=0, all weights 0, bias=0, and the error flag and index cleared; this SHALL apply in any state, including mid-epoch.
REQ-039 Sample-memory contents SHALL NOT be required to be cleared by reset.

Verification
REQ-040 Scenario 1, default parameters, OR table loaded (addr0..3: x=00/01/10/11, y=0/1/1/1), thr=1, max_ep=10, start -> done pulse, converged=1, epochs_used=4, w[0]=1, w[1]=1, bias=0.
REQ-041 Scenario 2, same as scenario 1 but max_ep=2 -> done after 2 epochs (16 cycles of EVAL/UPDATE), converged=0, epochs_used=2, w[0]=1, w[1]=1, bias=1.
REQ-042 Scenario 3, WW=4, all samples x=00, y=0, thr=-8, max_ep=12 -> bias decrements each sample and saturates at -8 with no wrap, converged=0, epochs_used=12.
REQ-043 Scenario 4, max_ep=0, start -> FIN on the next edge, done pulse, busy never 1, converged=0, epochs_used=0.
REQ-044 Scenario 5, during a run apply start=1, wr_en=1, and changes to thr/max_ep -> no restart, memory unchanged, results identical to scenario 1.
REQ-045 Scenario 6, assert rst mid-epoch during UPDATE -> outputs reach their reset values without waiting for a clock edge; a fresh start afterwards reproduces scenario 1.

Source files
------------

// File: rtl/perceptron_train_if.sv
// Bundle of control, sample-write and result signals for perceptron_train.
// The training engine attaches through the slave modport, its user through master.
interface perceptron_train_if #(
    parameter int unsigned NIN   = 2,
    parameter int unsigned WW    = 8,
    parameter int unsigned NSAMP = 4,
    parameter int unsigned EPW   = 4
);
    localparam int unsigned AW = $clog2(NSAMP);

    logic                   start;
    logic [EPW-1:0]         max_ep;
    logic signed [WW-1:0]   thr;
    logic                   wr_en;
    logic [AW-1:0]          wr_addr;
    logic [NIN-1:0]         wr_x;
    logic                   wr_y;

    logic                   busy;
    logic                   done;
    logic                   converged;
    logic [EPW-1:0]         epochs_used;
    logic [NIN*WW-1:0]      w_flat;
    logic signed [WW-1:0]   bias;

    modport master (
        output start, max_ep, thr, wr_en, wr_addr, wr_x, wr_y,
        input  busy, done, converged, epochs_used, w_flat, bias
    );

    modport slave (
        input  start, max_ep, thr, wr_en, wr_addr, wr_x, wr_y,
        output busy, done, converged, epochs_used, w_flat, bias
    );
endinterface

// File: rtl/perceptron_train.sv
// Single-layer perceptron trainer over a small on-chip sample memory.
// Each sample takes one EVAL and one UPDATE cycle; epochs repeat until error-free or max_ep.
module perceptron_train #(
    parameter int unsigned NIN   = 2,
    parameter int unsigned WW    = 8,
    parameter int unsigned NSAMP = 4,
    parameter int unsigned EPW   = 4
) (
    input  logic              clk,
    input  logic              rst,
    perceptron_train_if.slave bus_io
);
    localparam int unsigned AW = $clog2(NSAMP);
    // Wide enough that bias plus all NIN weights can never overflow.
    localparam int unsigned SW = WW + $clog2(NIN + 1);

    typedef enum logic [2:0] {StIdle, StEval, StUpdate, StEpend, StFin} state_e;

    state_e               state_q, state_d;
    logic signed [WW-1:0] w_q [NIN];
    logic signed [WW-1:0] w_d [NIN];
    logic signed [WW-1:0] bias_q, bias_d;
    logic [AW-1:0]        idx_q, idx_d;
    logic [EPW-1:0]       ep_q, ep_d;
    logic [EPW-1:0]       max_ep_q, max_ep_d;
    logic signed [WW-1:0] thr_q, thr_d;
    logic                 conv_q, conv_d;
    logic                 eflag_q, eflag_d;
    logic signed [1:0]    err_q, err_d;

    logic [NIN-1:0]       x_mem [NSAMP];
    logic                 y_mem [NSAMP];

    logic [NIN-1:0]       x_cur;
    logic                 y_cur;
    logic signed [SW-1:0] sum;
    logic                 y_pred;
    logic signed [1:0]    err_calc;
    logic                 wr_ok;

    function automatic logic signed [WW-1:0] sat_add(input logic signed [WW-1:0] a,
                                                     input logic signed [1:0]    d);
        logic signed [WW:0] s;
        s = (WW+1)'(a) + (WW+1)'(d);
        if (s[WW] != s[WW-1]) begin
            sat_add = s[WW] ? {1'b1, {(WW-1){1'b0}}} : {1'b0, {(WW-1){1'b1}}};
        end else begin
            sat_add = s[WW-1:0];
        end
    endfunction

    assign wr_ok = bus_io.wr_en && !bus_io.busy && ({1'b0, bus_io.wr_addr} < (AW+1)'(NSAMP));

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            x_mem[bus_io.wr_addr] <= bus_io.wr_x;
            y_mem[bus_io.wr_addr] <= bus_io.wr_y;
        end
    end

    assign x_cur = x_mem[idx_q];
    assign y_cur = y_mem[idx_q];

    always_comb begin
        sum = SW'(bias_q);
        for (int i = 0; i < NIN; i++) begin
            if (x_cur[i]) sum = sum + SW'(w_q[i]);
        end
    end

    assign y_pred = (sum >= SW'(thr_q));

    always_comb begin
        err_calc = 2'b00;
        if (y_cur && !y_pred) err_calc = 2'b01;
        else if (!y_cur && y_pred) err_calc = 2'b11;
    end

    always_comb begin
        state_d  = state_q;
        w_d      = w_q;
        bias_d   = bias_q;
        idx_d    = idx_q;
        ep_d     = ep_q;
        max_ep_d = max_ep_q;
        thr_d    = thr_q;
        conv_d   = conv_q;
        eflag_d  = eflag_q;
        err_d    = err_q;
        unique case (state_q)
            StIdle: begin
                if (bus_io.start) begin
                    for (int i = 0; i < NIN; i++) w_d[i] = '0;
                    bias_d   = '0;
                    idx_d    = '0;
                    ep_d     = '0;
                    conv_d   = 1'b0;
                    eflag_d  = 1'b0;
                    max_ep_d = bus_io.max_ep;
                    thr_d    = bus_io.thr;
                    state_d  = (bus_io.max_ep == '0) ? StFin : StEval;
                end
            end
            StEval: begin
                err_d = err_calc;
                if (err_calc != 2'b00) eflag_d = 1'b1;
                state_d = StUpdate;
            end
            StUpdate: begin
                for (int i = 0; i < NIN; i++) begin
                    if (x_cur[i]) w_d[i] = sat_add(w_q[i], err_q);
                end
                bias_d = sat_add(bias_q, err_q);
                if (idx_q == AW'(NSAMP - 1)) begin
                    ep_d    = ep_q + EPW'(1);
                    state_d = StEpend;
                end else begin
                    idx_d   = idx_q + AW'(1);
                    state_d = StEval;
                end
            end
            StEpend: begin
                if (!eflag_q) begin
                    conv_d  = 1'b1;
                    state_d = StFin;
                end else if (ep_q == max_ep_q) begin
                    state_d = StFin;
                end else begin
                    eflag_d = 1'b0;
                    idx_d   = '0;
                    state_d = StEval;
                end
            end
            StFin: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            w_q      <= '{default: '0};
            bias_q   <= '0;
            idx_q    <= '0;
            ep_q     <= '0;
            max_ep_q <= '0;
            thr_q    <= '0;
            conv_q   <= 1'b0;
            eflag_q  <= 1'b0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            w_q      <= w_d;
            bias_q   <= bias_d;
            idx_q    <= idx_d;
            ep_q     <= ep_d;
            max_ep_q <= max_ep_d;
            thr_q    <= thr_d;
            conv_q   <= conv_d;
            eflag_q  <= eflag_d;
            err_q    <= err_d;
        end
    end

    assign bus_io.busy        = (state_q == StEval) || (state_q == StUpdate) ||
                                (state_q == StEpend);
    assign bus_io.done        = (state_q == StFin);
    assign bus_io.converged   = conv_q;
    assign bus_io.epochs_used = ep_q;
    assign bus_io.bias        = bias_q;

    always_comb begin
        bus_io.w_flat = '0;
        for (int i = 0; i < NIN; i++) bus_io.w_flat[i*WW +: WW] = w_q[i];
    end
endmodule

// File: tb/tb_perceptron_train.sv
// Directed bench for perceptron_train: OR-table training, epoch limit, bias saturation
// with a 4-bit instance, zero-epoch start, ignored mid-run inputs and async reset.
module tb_perceptron_train;
    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   nbusy;

    perceptron_train_if #(.NIN(2), .WW(8), .NSAMP(4), .EPW(4)) bus0 ();
    perceptron_train_if #(.NIN(2), .WW(4), .NSAMP(4), .EPW(4)) bus1 ();

    perceptron_train #(.NIN(2), .WW(8), .NSAMP(4), .EPW(4)) dut0 (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus0)
    );

    perceptron_train #(.NIN(2), .WW(4), .NSAMP(4), .EPW(4)) dut1 (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wr0(input logic [1:0] a, input logic [1:0] x, input logic y);
        bus0.wr_en = 1'b1; bus0.wr_addr = a; bus0.wr_x = x; bus0.wr_y = y;
        @(negedge clk);
        bus0.wr_en = 1'b0;
    endtask

    task automatic wr1(input logic [1:0] a, input logic [1:0] x, input logic y);
        bus1.wr_en = 1'b1; bus1.wr_addr = a; bus1.wr_x = x; bus1.wr_y = y;
        @(negedge clk);
        bus1.wr_en = 1'b0;
    endtask

    task automatic start0(input logic [3:0] mep, input logic signed [7:0] th);
        bus0.max_ep = mep; bus0.thr = th; bus0.start = 1'b1;
        @(negedge clk);
        bus0.start = 1'b0;
    endtask

    // Bounded wait for done on dut0; counts busy cycles seen on the way.
    task automatic wait_done0(input int budget, output int nb);
        nb = 0;
        for (int n = 0; n < budget && bus0.done !== 1'b1; n++) begin
            if (bus0.busy === 1'b1) nb++;
            @(negedge clk);
        end
        check("done0_seen", bus0.done, 1);
        check("done0_not_busy", bus0.busy, 0);
        @(negedge clk);
        check("done0_one_cycle", bus0.done, 0);
    endtask

    task automatic check_or_result(input string tag);
        check({tag, "_conv"}, bus0.converged, 1);
        check({tag, "_ep"}, bus0.epochs_used, 4);
        check({tag, "_w0"}, $signed(bus0.w_flat[7:0]), 1);
        check({tag, "_w1"}, $signed(bus0.w_flat[15:8]), 1);
        check({tag, "_bias"}, bus0.bias, 0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus0.start = 1'b0; bus0.max_ep = '0; bus0.thr = '0;
        bus0.wr_en = 1'b0; bus0.wr_addr = '0; bus0.wr_x = '0; bus0.wr_y = 1'b0;
        bus1.start = 1'b0; bus1.max_ep = '0; bus1.thr = '0;
        bus1.wr_en = 1'b0; bus1.wr_addr = '0; bus1.wr_x = '0; bus1.wr_y = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", bus0.busy, 0);
        check("rst_done", bus0.done, 0);
        check("rst_conv", bus0.converged, 0);
        check("rst_ep", bus0.epochs_used, 0);
        check("rst_w", bus0.w_flat, 0);
        check("rst_bias", bus0.bias, 0);
        rst = 1'b0;
        @(negedge clk);

        // OR table into dut0, all-zero/y=0 into dut1
        wr0(2'd0, 2'b00, 1'b0);
        wr0(2'd1, 2'b01, 1'b1);
        wr0(2'd2, 2'b10, 1'b1);
        wr0(2'd3, 2'b11, 1'b1);
        for (int a = 0; a < 4; a++) wr1(2'(a), 2'b00, 1'b0);

        // Scenario 1: converges after 4 epochs, 4*(8+1) busy cycles
        start0(4'd10, 8'sd1);
        wait_done0(200, nbusy);
        check("s1_busy_cycles", nbusy, 36);
        check_or_result("s1");
        repeat (3) @(negedge clk);
        check("s1_hold_w", bus0.w_flat, 16'h0101);
        check("s1_hold_ep", bus0.epochs_used, 4);

        // Scenario 2: epoch limit of 2
        start0(4'd2, 8'sd1);
        wait_done0(200, nbusy);
        check("s2_busy_cycles", nbusy, 18);
        check("s2_conv", bus0.converged, 0);
        check("s2_ep", bus0.epochs_used, 2);
        check("s2_w0", $signed(bus0.w_flat[7:0]), 1);
        check("s2_w1", $signed(bus0.w_flat[15:8]), 1);
        check("s2_bias", bus0.bias, 1);

        // Scenario 3: 4-bit bias driven down to -8 and held there
        bus1.max_ep = 4'd12; bus1.thr = 4'sb1000; bus1.start = 1'b1;
        @(negedge clk);
        bus1.start = 1'b0;
        for (int n = 0; n < 300 && bus1.done !== 1'b1; n++) @(negedge clk);
        check("s3_done", bus1.done, 1);
        check("s3_bias", bus1.bias, -8);
        check("s3_conv", bus1.converged, 0);
        check("s3_ep", bus1.epochs_used, 12);
        check("s3_w", bus1.w_flat, 0);

        // Scenario 4: zero epochs goes straight to FIN and clears prior results
        start0(4'd0, 8'sd1);
        check("s4_done", bus0.done, 1);
        check("s4_busy", bus0.busy, 0);
        check("s4_conv", bus0.converged, 0);
        check("s4_ep", bus0.epochs_used, 0);
        check("s4_bias", bus0.bias, 0);
        check("s4_w", bus0.w_flat, 0);
        @(negedge clk);
        check("s4_done_off", bus0.done, 0);

        // Scenario 5: start, write and new thr/max_ep during the run must be ignored
        start0(4'd10, 8'sd1);
        @(negedge clk);
        bus0.start = 1'b1; bus0.wr_en = 1'b1; bus0.wr_addr = 2'd0;
        bus0.wr_x = 2'b11; bus0.wr_y = 1'b1; bus0.thr = 8'sd5; bus0.max_ep = 4'd1;
        @(negedge clk);
        bus0.start = 1'b0; bus0.wr_en = 1'b0;
        wait_done0(200, nbusy);
        check("s5_busy_cycles", nbusy, 34);
        check_or_result("s5");

        // Scenario 6: async reset during UPDATE of epoch 2, sample 0
        start0(4'd10, 8'sd1);
        repeat (10) @(negedge clk);
        check("s6_pre_busy", bus0.busy, 1);
        check("s6_pre_ep", bus0.epochs_used, 1);
        check("s6_pre_bias", bus0.bias, 1);
        check("s6_pre_w0", $signed(bus0.w_flat[7:0]), 1);
        #1 rst = 1'b1;
        #1;
        check("s6_rst_busy", bus0.busy, 0);
        check("s6_rst_done", bus0.done, 0);
        check("s6_rst_ep", bus0.epochs_used, 0);
        check("s6_rst_bias", bus0.bias, 0);
        check("s6_rst_w", bus0.w_flat, 0);
        check("s6_rst_conv", bus0.converged, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        start0(4'd10, 8'sd1);
        wait_done0(200, nbusy);
        check("s6_busy_cycles", nbusy, 36);
        check_or_result("s6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
